mod_exp_lr: RTL and testbench
=============================

// Module: mod_exp_lr
// PURPOSE
//  Left-to-right (MSB-first) modular exponentiation y = a^pwr mod m over a single montgomery_mul
//  instance. Successor to the right-to-left exponentiator: performs its own Montgomery domain
//  entry/exit, processes a run-time exponent length, supports abort and length error. Sits in gpcfg
//  below the register/DMA front end, which supplies operands and precomputed r2/r_red.
// PARAMETERS
//  NBITS   2048  operand/modulus width; montgomery_mul instantiated at same NBITS
//  SIZEW   12    width of m_size and e_size; must satisfy 2^SIZEW > NBITS
// PORTS
//  clk       in   1      clock
//  rst_n     in   1      reset, asynchronous, active-low
//  start_p   in   1      1-cycle start pulse; operands sampled in same cycle
//  abort_p   in   1      1-cycle abort pulse; cancels operation, no done_p
//  a         in   NBITS  base, a < m
//  r2        in   NBITS  R^2 mod m (R as defined by montgomery_mul for m_size)
//  r_red     in   NBITS  R mod m (Montgomery one)
//  pwr       in   NBITS  exponent
//  e_size    in   SIZEW  exponent bits processed, pwr[e_size-1:0]; 0 allowed
//  m         in   NBITS  odd modulus, m > 1
//  m_size    in   SIZEW  modulus bit length, passed to montgomery_mul
//  busy      out  1      high whenever FSM not in IDLE
//  y         out  NBITS  result, registered, held until next done_p
//  done_p    out  1      1-cycle pulse, y valid in same cycle
//  err_p     out  1      1-cycle pulse, start rejected (e_size > NBITS)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, internal regs 0. Async reset mid-operation returns to IDLE at
//    once; multiplier is reset by same rst_n.
//  - start_p in IDLE: latch a,r2,r_red,pwr,e_size,m,m_size; e_size > NBITS -> err_p next cycle, stay
//    IDLE. start_p while busy ignored (no err_p). Latched copies used throughout; inputs may change.
//  - Mult launch: mm_en pulse exactly one cycle per mult; operands held stable until mm_done. One
//    mult in flight max. Result in acc/base on mm_done cycle.
//  - FSM: IDLE -> TOMONT: base = mont(a,r2), acc = r_red, idx = e_size.
//    TOMONT -(mm_done)-> SCAN.  SCAN: idx==0 -> FROMMONT; else idx<=idx-1 -> SQR.
//    SQR: acc = mont(acc,acc) -(mm_done)-> bit=pwr[idx]: 1 -> MUL, 0 -> SCAN.
//    MUL: acc = mont(acc,base) -(mm_done)-> SCAN.
//    FROMMONT: y_nxt = mont(acc,1) -(mm_done)-> y<=result, done_p=1 next cycle, -> IDLE.
//  - e_size==0: TOMONT then FROMMONT only; y = 1. pwr bits >= e_size ignored.
//  - Mult count per op (no CT): 2 + e_size + popcount(pwr[e_size-1:0]).
//  - abort_p: if no mult in flight -> IDLE next cycle; if in flight -> DRAIN, wait mm_done, discard,
//    -> IDLE. busy stays high in DRAIN. abort_p in IDLE ignored. abort_p same cycle as start_p in
//    IDLE: abort wins, nothing latched. abort_p same cycle as FROMMONT mm_done: abort wins, y unchanged.
//  - y only updated on done_p; y not updated on abort or error.
// CONFIGURATION
//  MOD_EXP_CT_EN defined: constant-time; SQR always -> MUL; MUL computes mont(acc,base) for every
//   bit, acc updated only when bit=1 (result discarded otherwise). Mult count 2 + 2*e_size,
//   cycle count independent of pwr value.
//  Undefined: MUL executed only for 1-bits, as above.
// TESTING
//  NBITS=16: m=13, a=2, pwr=10, e_size=4 -> y=10, done_p once, 8 mults (10 with MOD_EXP_CT_EN).
//  pwr=0xFFFF, e_size=0, a=5, m=13 -> y=1, exactly 2 mults, busy drops with done_p.
//  e_size=17 at NBITS=16 -> err_p 1 cycle later, busy never high, y unchanged.
//  abort_p mid-SQR -> DRAIN until mm_done, then IDLE; no done_p; following start a=3,pwr=5,
//   e_size=3, m=13 -> y=9.
//  start_p pulsed while busy -> ignored; current op completes with correct y, one done_p.
//  CT build: pwr=0x8000 vs 0x7FFF, e_size=16 -> identical start-to-done_p cycle counts, y correct.

Source files
------------

// File: rtl/mod_exp_lr.sv
// ---------------------------------------------------------------------------
// mod_exp_lr : left-to-right (MSB-first) modular exponentiation y = a^pwr mod m
//   built around one bit-serial Montgomery multiplier (R = 2^m_size).
//   Operands are moved into the Montgomery domain at the start of the operation
//   and moved back out at the end.
//
// Optional feature macro: MOD_EXP_CT_EN
//   When it is defined, every exponent bit costs one square and one multiply,
//   so the run time does not depend on the exponent value.
//
// Ports (mod_exp_lr)
//   clk, rst_n        clock, asynchronous active-low reset
//   start_p, abort_p  1-cycle start / abort pulses
//   a, r2, r_red      base, R^2 mod m, R mod m
//   pwr, e_size       exponent and the number of its low bits to process
//   m, m_size         odd modulus and its bit length
//   busy              FSM not idle
//   y, done_p         registered result, 1-cycle completion pulse
//   err_p             1-cycle pulse when a start is rejected (e_size > NBITS)
//
// Ports (montgomery_mul)
//   en                1-cycle launch; b, m and m_size must stay stable until done
//   a, b, m, m_size   operands, a,b < m
//   done, y           1-cycle pulse, y = a*b*2^-m_size mod m
// ---------------------------------------------------------------------------
module montgomery_mul #(
    parameter int NBITS = 2048,
    parameter int SIZEW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    input  logic [SIZEW-1:0] m_size,
    output logic             done,
    output logic [NBITS-1:0] y
);
    // The partial sum stays below 4m, which needs two guard bits.
    localparam int TW = NBITS + 2;

    function automatic logic [NBITS-1:0] cond_sub(input logic [TW-1:0] t,
                                                  input logic [NBITS-1:0] md);
        logic [TW-1:0] diff;
        diff = t - {2'b00, md};
        if (t >= {2'b00, md}) return diff[NBITS-1:0];
        return t[NBITS-1:0];
    endfunction

    logic             busy_q, busy_d;
    logic [SIZEW-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    t_q, t_d;
    logic [NBITS-1:0] a_q, a_d;
    logic             done_q, done_d;
    logic [NBITS-1:0] y_q, y_d;
    logic [TW-1:0]    sum, sum_odd;

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        a_d     = a_q;
        done_d  = 1'b0;
        y_d     = y_q;
        // One radix-2 step: add a_i*b, make the sum even with m, halve it.
        sum     = t_q + (a_q[0] ? {2'b00, b} : {TW{1'b0}});
        sum_odd = sum[0] ? (sum + {2'b00, m}) : sum;
        if (en) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            t_d    = '0;
            a_d    = a;
        end else if (busy_q) begin
            if (cnt_q == m_size) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                y_d    = cond_sub(t_q, m);
            end else begin
                t_d   = sum_odd >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + SIZEW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            t_q    <= '0;
            a_q    <= '0;
            done_q <= 1'b0;
            y_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            t_q    <= t_d;
            a_q    <= a_d;
            done_q <= done_d;
            y_q    <= y_d;
        end
    end

    assign done = done_q;
    assign y    = y_q;
endmodule

module mod_exp_lr #(
    parameter int NBITS = 2048,
    parameter int SIZEW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic             abort_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] r2,
    input  logic [NBITS-1:0] r_red,
    input  logic [NBITS-1:0] pwr,
    input  logic [SIZEW-1:0] e_size,
    input  logic [NBITS-1:0] m,
    input  logic [SIZEW-1:0] m_size,
    output logic             busy,
    output logic [NBITS-1:0] y,
    output logic             done_p,
    output logic             err_p
);
`ifdef MOD_EXP_CT_EN
    localparam bit CT_EN = 1'b1;
`else
    localparam bit CT_EN = 1'b0;
`endif
    localparam logic [SIZEW-1:0] NBITS_SZ = SIZEW'(NBITS);

    typedef enum logic [2:0] {
        S_IDLE, S_TOMONT, S_SCAN, S_SQR, S_MUL, S_FROMMONT, S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] acc_q, acc_d, base_q, base_d, pwr_sh_q, pwr_sh_d;
    logic [NBITS-1:0] m_q, m_d, mm_a_q, mm_a_d, mm_b_q, mm_b_d, y_q, y_d;
    logic [SIZEW-1:0] idx_q, idx_d, m_size_q, m_size_d;
    logic             cur_bit_q, cur_bit_d, mm_en_q, mm_en_d;
    logic             done_q, done_d, err_q, err_d;
    logic             mm_done, mult_active;
    logic [NBITS-1:0] mm_res;

    montgomery_mul #(.NBITS(NBITS), .SIZEW(SIZEW)) u_mm (
        .clk(clk), .rst_n(rst_n), .en(mm_en_q), .a(mm_a_q), .b(mm_b_q),
        .m(m_q), .m_size(m_size_q), .done(mm_done), .y(mm_res)
    );

    assign mult_active = (state_q == S_TOMONT) || (state_q == S_SQR) ||
                         (state_q == S_MUL) || (state_q == S_FROMMONT);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        base_d    = base_q;
        pwr_sh_d  = pwr_sh_q;
        m_d       = m_q;
        mm_a_d    = mm_a_q;
        mm_b_d    = mm_b_q;
        y_d       = y_q;
        idx_d     = idx_q;
        m_size_d  = m_size_q;
        cur_bit_d = cur_bit_q;
        mm_en_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (abort_p && state_q != S_IDLE && state_q != S_DRAIN) begin
            // A multiply that has not finished must be drained before reuse.
            state_d = (mult_active && !mm_done) ? S_DRAIN : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_p && !abort_p) begin
                        if (e_size > NBITS_SZ) begin
                            err_d = 1'b1;
                        end else begin
                            // Exponent is left-aligned so the next bit is always the MSB.
                            pwr_sh_d = pwr << (NBITS_SZ - e_size);
                            idx_d    = e_size;
                            m_d      = m;
                            m_size_d = m_size;
                            acc_d    = r_red;
                            mm_a_d   = a;
                            mm_b_d   = r2;
                            mm_en_d  = 1'b1;
                            state_d  = S_TOMONT;
                        end
                    end
                end
                S_TOMONT: begin
                    if (mm_done) begin
                        base_d  = mm_res;
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    mm_a_d  = acc_q;
                    mm_en_d = 1'b1;
                    if (idx_q == '0) begin
                        mm_b_d  = NBITS'(1);
                        state_d = S_FROMMONT;
                    end else begin
                        idx_d     = idx_q - SIZEW'(1);
                        cur_bit_d = pwr_sh_q[NBITS-1];
                        pwr_sh_d  = pwr_sh_q << 1;
                        mm_b_d    = acc_q;
                        state_d   = S_SQR;
                    end
                end
                S_SQR: begin
                    if (mm_done) begin
                        acc_d = mm_res;
                        if (cur_bit_q || CT_EN) begin
                            mm_a_d  = mm_res;
                            mm_b_d  = base_q;
                            mm_en_d = 1'b1;
                            state_d = S_MUL;
                        end else begin
                            state_d = S_SCAN;
                        end
                    end
                end
                S_MUL: begin
                    if (mm_done) begin
                        // In constant-time mode a 0-bit product is computed and dropped.
                        if (cur_bit_q) acc_d = mm_res;
                        state_d = S_SCAN;
                    end
                end
                S_FROMMONT: begin
                    if (mm_done) begin
                        y_d     = mm_res;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mm_done) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            base_q    <= '0;
            pwr_sh_q  <= '0;
            m_q       <= '0;
            mm_a_q    <= '0;
            mm_b_q    <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            m_size_q  <= '0;
            cur_bit_q <= 1'b0;
            mm_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            base_q    <= base_d;
            pwr_sh_q  <= pwr_sh_d;
            m_q       <= m_d;
            mm_a_q    <= mm_a_d;
            mm_b_q    <= mm_b_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
            m_size_q  <= m_size_d;
            cur_bit_q <= cur_bit_d;
            mm_en_q   <= mm_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign y      = y_q;
    assign done_p = done_q;
    assign err_p  = err_q;
endmodule

// File: tb/tb_mod_exp_lr.sv
module tb_mod_exp_lr;
    localparam int NBITS = 16;
    localparam int SIZEW = 5;
    localparam int TMO   = 3000;

    logic             clk = 1'b0;
    logic             rst_n, start_p, abort_p;
    logic [NBITS-1:0] a, r2, r_red, pwr, m, y;
    logic [SIZEW-1:0] e_size, m_size;
    logic             busy, done_p, err_p;

    int n_checks = 0, n_errors = 0;
    int mm_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;

    mod_exp_lr #(.NBITS(NBITS), .SIZEW(SIZEW)) dut (
        .clk(clk), .rst_n(rst_n), .start_p(start_p), .abort_p(abort_p),
        .a(a), .r2(r2), .r_red(r_red), .pwr(pwr), .e_size(e_size),
        .m(m), .m_size(m_size), .busy(busy), .y(y), .done_p(done_p), .err_p(err_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.mm_en_q) mm_cnt <= mm_cnt + 1;
        if (done_p)      done_cnt <= done_cnt + 1;
        if (err_p)       err_cnt <= err_cnt + 1;
        if (busy)        busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_exp(longint b, longint p, int e, longint md);
        longint r = 1;
        for (int i = e - 1; i >= 0; i--) begin
            r = (r * r) % md;
            if ((p >> i) & 1) r = (r * b) % md;
        end
        return r % md;
    endfunction

    function automatic int bitlen(longint v);
        int n = 0;
        while (v != 0) begin n++; v = v >> 1; end
        return n;
    endfunction

    function automatic int exp_mults(longint p, int e);
        int pc = 0;
        for (int i = 0; i < e; i++) pc += int'((p >> i) & 1);
`ifdef MOD_EXP_CT_EN
        return 2 + 2 * e;
`else
        return 2 + e + pc;
`endif
    endfunction

    task automatic set_ops(input longint aa, input longint pp, input int e, input longint mm);
        int ms;
        ms     = bitlen(mm);
        a      = NBITS'(aa);
        pwr    = NBITS'(pp);
        e_size = SIZEW'(e);
        m      = NBITS'(mm);
        m_size = SIZEW'(ms);
        r2     = NBITS'((longint'(1) << (2 * ms)) % mm);
        r_red  = NBITS'((longint'(1) << ms) % mm);
    endtask

    // Pulse start, then scramble the inputs: the DUT must work from its own copies.
    task automatic launch(input longint aa, input longint pp, input int e, input longint mm);
        @(posedge clk); #1;
        set_ops(aa, pp, e, mm);
        start_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0;
        a = NBITS'($urandom); pwr = NBITS'($urandom); m = NBITS'($urandom);
        r2 = NBITS'($urandom); r_red = NBITS'($urandom);
        e_size = SIZEW'($urandom); m_size = SIZEW'($urandom);
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < TMO && !ok) begin
            if (done_p) ok = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
    endtask

    task automatic run_op(input string tag, input longint aa, input longint pp,
                          input int e, input longint mm, output int cyc);
        int m0, d0;
        bit ok;
        m0 = mm_cnt; d0 = done_cnt;
        launch(aa, pp, e, mm);
        wait_done(cyc, ok);
        chk({tag, "_timeout"}, 32'(ok), 32'd1);
        chk({tag, "_y"}, 32'(y), 32'(ref_exp(aa, pp, e, mm)));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_mults"}, 32'(mm_cnt - m0), 32'(exp_mults(pp, e)));
        chk({tag, "_done_low"}, 32'(done_p), 32'd0);
    endtask

    initial begin
        int cyc, cyc2, d0, m0, e0, b0, n;
        logic [NBITS-1:0] y_prev;
        bit ok;
        rst_n = 1'b0; start_p = 1'b0; abort_p = 1'b0;
        set_ops(0, 0, 0, 13);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_p), 32'd0);
        chk("rst_err", 32'(err_p), 32'd0);
        rst_n = 1'b1;

        run_op("basic", 2, 10, 4, 13, cyc);
        run_op("esize0", 5, 16'hFFFF, 0, 13, cyc);
        chk("esize0_yval", 32'(y), 32'd1);

        // Rejected start: err_p one cycle later, never busy, y kept.
        y_prev = y; b0 = busy_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        set_ops(3, 7, 17, 13);
        start_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0;
        chk("err_pulse", 32'(err_p), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("err_pulse_end", 32'(err_p), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_count", 32'(err_cnt - e0), 32'd1);
        chk("err_never_busy", 32'(busy_cnt - b0), 32'd0);
        chk("err_y_kept", 32'(y), 32'(y_prev));

        // Abort together with start in IDLE: nothing happens.
        m0 = mm_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        set_ops(3, 5, 3, 13);
        start_p = 1'b1; abort_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0; abort_p = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_start_mults", 32'(mm_cnt - m0), 32'd0);

        // Abort during the first square.
        y_prev = y; d0 = done_cnt; m0 = mm_cnt;
        launch(7, 16'hBEEF, 16, 16'hFFF1);
        n = 0;
        while (mm_cnt < m0 + 2 && n < TMO) begin @(posedge clk); #1; n++; end
        chk("abort_reach_sqr", 32'(n < TMO), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        abort_p = 1'b1;
        @(posedge clk); #1;
        abort_p = 1'b0;
        chk("abort_drain_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < TMO) begin @(posedge clk); #1; n++; end
        chk("abort_idle", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_y_kept", 32'(y), 32'(y_prev));
        run_op("after_abort", 3, 5, 3, 13, cyc);
        chk("after_abort_val", 32'(y), 32'd9);

        // Start while busy is ignored, including a would-be length error.
        d0 = done_cnt; e0 = err_cnt;
        launch(2, 10, 4, 13);
        repeat (4) @(posedge clk);
        #1;
        set_ops(5, 3, 17, 11);
        start_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0;
        set_ops(6, 1, 2, 11);
        start_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0;
        wait_done(cyc, ok);
        chk("busy_start_timeout", 32'(ok), 32'd1);
        chk("busy_start_y", 32'(y), 32'd10);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_start_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_start_err", 32'(err_cnt - e0), 32'd0);
        chk("busy_start_idle", 32'(busy), 32'd0);

        // Exponents with very different weight.
        run_op("w_hi", 12345, 16'h8000, 16, 65521, cyc);
        run_op("w_lo", 12345, 16'h7FFF, 16, 65521, cyc2);
`ifdef MOD_EXP_CT_EN
        chk("ct_cycles", 32'(cyc2), 32'(cyc));
`endif

        for (int i = 0; i < 20; i++) begin
            longint rm, ra, rp;
            int re;
            rm = longint'($urandom_range(1, 32767)) * 2 + 1;
            ra = longint'($urandom) % rm;
            rp = longint'($urandom_range(0, 65535));
            re = int'($urandom_range(0, 16));
            run_op($sformatf("rnd%0d", i), ra, rp, re, rm, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
